// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns/InvMixColumns engine: valid/ready in, column-serial transform, valid/ready out.
// Optional inverse datapath compiled in when MIX_COLUMNS_INV_EN is defined.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_work;
  logic [127:0] w_work_next;
  logic [1:0]   r_cnt;
  logic [2:0]   w_cnt_sum;
  logic         w_last;
  logic         w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      x[i] = xtime(a[i]);
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = x[i] ^ x[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction

  logic r_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_inv <= inv;
    end
  end
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif

  // One mixer per column slot; slot gi works on column r_cnt + gi.
  logic [1:0]  w_col_idx [COLS_PER_CYCLE];
  logic [31:0] w_col_in  [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];

  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_mix
      assign w_col_idx[gi] = r_cnt + 2'(gi);
      assign w_col_in[gi]  = r_work[7'd127 - {w_col_idx[gi], 5'd0} -: 32];
`ifdef MIX_COLUMNS_INV_EN
      assign w_col_out[gi] = r_inv ? inv_col(w_col_in[gi]) : fwd_col(w_col_in[gi]);
`else
      assign w_col_out[gi] = fwd_col(w_col_in[gi]);
`endif
    end
  endgenerate

  assign w_cnt_sum = {1'b0, r_cnt} + 3'(COLS_PER_CYCLE);
  assign w_last    = w_cnt_sum[2];
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
    state_out = (r_state == S_DONE) ? r_work : 128'h0;
  end

  always_comb begin
    w_work_next = r_work;
    if (w_accept) begin
      w_work_next = state_in;
    end else if (r_state == S_BUSY) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        w_work_next[7'd127 - {w_col_idx[k], 5'd0} -: 32] = w_col_out[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= 128'h0;
      r_cnt  <= 2'd0;
    end else begin
      r_work <= w_work_next;
      if (w_accept) begin
        r_cnt <= 2'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_cnt_sum[1:0];
      end
    end
  end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Parametrised, sequential AES MixColumns/InvMixColumns engine for the encryption/decryption round datapath. It accepts a full 128-bit state over a valid/ready handshake and transforms it column-serially, processing COLS_PER_CYCLE columns per clock. It returns the result over a second valid/ready handshake. It supersedes the single-byte combinational GF(2^8) mixer and adds an inverse mode and flow control.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values are 1, 2 and 4, and any other value is an elaboration error.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  engine can accept a state.
- inv  input  1  mode, sampled on accept: 0 selects MixColumns, 1 selects InvMixColumns.
- state_in  input  128  input state; column c = bits [127-32c -: 32], row 0 in the column's MSB byte.
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  transformed state, same byte ordering as state_in.

## Operation
- FSM states are IDLE, BUSY and DONE; reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch state_in into the working register, latch inv, clear the column counter (2 bits), go to BUSY.
- BUSY:
  - Each cycle, replace columns cnt .. cnt+COLS_PER_CYCLE-1 of the working register with their transformed value.
  - Then cnt += COLS_PER_CYCLE.
  - After column 3 is written, go to DONE. The counter wraps to 0 and is not otherwise used.
- DONE:
  - out_valid = 1 and state_out = working register.
  - Both are held stable until out_ready = 1; on that edge go to IDLE.
- in_ready = 1 only in IDLE with rst low. There is no accept in DONE or BUSY, even when out_ready is high in the same cycle.
- Column transform, for column bytes a0..a3 in GF(2^8) with polynomial 0x11B:
  - Forward: b_i = 02·a_i ^ 03·a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4.
  - Inverse: b_i = 0e·a_i ^ 0b·a_(i+1) ^ 0d·a_(i+2) ^ 09·a_(i+3).
- Multiplication is built only from xtime (shift left 1, XOR 0x1B if bit 7 was set) and XOR. No lookup tables, no `*` operator.
- Each column is computed combinationally within one cycle. There is no intra-column pipelining.
- in_valid, inv and state_in changes while not in IDLE are ignored.

## Timing
- Reset values: state = IDLE, out_valid = 0, state_out = 128'h0, working register = 0, counter = 0, in_ready = 0 while rst is high.
- Latency: with the accept at edge E, out_valid rises after edge E + 4/COLS_PER_CYCLE.
  - COLS_PER_CYCLE = 4: 1 cycle.
  - COLS_PER_CYCLE = 2: 2 cycles.
  - COLS_PER_CYCLE = 1: 4 cycles.
- Minimum accept-to-accept interval is 4/COLS_PER_CYCLE + 2 cycles (BUSY, DONE with out_ready = 1, then IDLE).
- Back-pressure: out_ready low in DONE stalls indefinitely with no change of state_out.
- rst high in any state: at the next edge the FSM is in IDLE, the in-flight state is discarded and out_valid = 0. rst has priority over every handshake.

## Configuration
- Macro: MIX_COLUMNS_INV_EN.
- Defined: the inverse datapath is compiled in and inv selects the mode as above.
- Undefined: the inverse logic is absent.
  - inv is ignored and every state receives the forward MixColumns.
  - The inv port remains present and unconnected internally.

## Test plan
- Forward, COLS_PER_CYCLE = 1: state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6, inv = 0 → state_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 4 cycles after accept.
- Inverse, COLS_PER_CYCLE = 4, with MIX_COLUMNS_INV_EN: state_in = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv = 1 → 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1-cycle latency. Without the macro, the same stimulus yields the forward transform of that input.
- Back-pressure, COLS_PER_CYCLE = 2: hold out_ready = 0 for 10 cycles in DONE → state_out stable, in_ready = 0 throughout. Releasing out_ready → IDLE next cycle, in_ready = 1.
- Reset mid-BUSY, COLS_PER_CYCLE = 1: assert rst for 1 cycle at BUSY cycle 2 → out_valid = 0, state_out = 0, in_ready = 1 after rst drops. A new accept then produces the correct result.
- Random regression, all three COLS_PER_CYCLE values: 1000 random states with inv toggled and random out_ready. Results must match a reference model; with the macro defined, forward-then-inverse returns the original state.
